// File: rtl/split_pipe_pkg.sv
// split_pipe shared types: word width, word type, pointer width helper.
// No ports; imported by the interface, FIFO and top.
package split_pipe_pkg;

  localparam int WORD_W = 128;

  typedef logic [WORD_W-1:0] word_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/split_pipe_if.sv
// Guarded enq method: ena (call), v (argument), rdy (guard).
// master calls the method, slave implements it.
interface split_pipe_if;
  import split_pipe_pkg::*;

  logic  ena;
  word_t v;
  logic  rdy;

  modport master (
    output ena,
    output v,
    input  rdy
  );

  modport slave (
    input  ena,
    input  v,
    output rdy
  );

endinterface

// File: rtl/split_pipe_fifo.sv
// Circular buffer for the forward path; sync write, comb head read.
// Ports: CLK, nRST, push/push_data, pop, head, full, empty.
module split_pipe_fifo
  import split_pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop,
  output word_t head,
  output logic  full,
  output logic  empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  word_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/split_pipe.sv
// One enq stream in; route bit clear -> out_enq (comb), set -> FIFO -> forward_enq.
// Ports: CLK, nRST, in_enq (slave), out_enq, forward_enq (masters). Option: SPLIT_PIPE_BYPASS_EN.
module split_pipe
  import split_pipe_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SEL_BIT = 127
) (
  input  logic  CLK,
  input  logic  nRST,
  split_pipe_if.slave  in_enq,
  split_pipe_if.master out_enq,
  split_pipe_if.master forward_enq
);

  logic  fwd_sel;
  logic  push;
  logic  pop;
  logic  byp;
  logic  full;
  logic  empty;
  word_t head;

  assign fwd_sel = in_enq.v[SEL_BIT];

  // Guard depends only on state and downstream ready, never on v;
  // full stalls the direct path too since routing follows acceptance.
  assign in_enq.rdy = out_enq.rdy & ~full;

  assign out_enq.ena = in_enq.ena & ~fwd_sel;
  assign out_enq.v   = in_enq.v;

`ifdef SPLIT_PIPE_BYPASS_EN
  assign byp = empty & forward_enq.rdy & in_enq.ena & fwd_sel;
`else
  assign byp = 1'b0;
`endif

  assign push = in_enq.ena & fwd_sel & ~byp;
  assign pop  = ~empty & forward_enq.rdy;

  assign forward_enq.ena = pop | byp;
  assign forward_enq.v   = byp ? in_enq.v : head;

  split_pipe_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (push),
    .push_data (in_enq.v),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_split_pipe.sv
// Self-checking bench for split_pipe: directed scenarios plus random traffic
// against a queue model of the forward path.
module tb_split_pipe;
  import split_pipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int SEL   = 127;
`ifdef SPLIT_PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  split_pipe_if in_enq ();
  split_pipe_if out_enq ();
  split_pipe_if forward_enq ();

  split_pipe #(
    .DEPTH   (DEPTH),
    .SEL_BIT (SEL)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .in_enq      (in_enq.slave),
    .out_enq     (out_enq.master),
    .forward_enq (forward_enq.master)
  );

  always #5 CLK = ~CLK;

  int    checks = 0;
  int    failures = 0;
  word_t q[$];
  logic  e_in_rdy, e_out_ena, e_fwd_ena, e_byp;
  word_t e_fwd_v;

  function automatic word_t fw(input int i);
    return {1'b1, 127'(i)};
  endfunction

  function automatic word_t rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply inputs, predict outputs from the queue model, wait to negedge.
  task automatic drive(input logic ena, input word_t v,
                       input logic ordy, input logic frdy);
    in_enq.ena      = ena;
    in_enq.v        = v;
    out_enq.rdy     = ordy;
    forward_enq.rdy = frdy;
    e_in_rdy  = ordy && (q.size() < DEPTH);
    e_out_ena = ena && !v[SEL];
    e_byp     = BYP && q.size() == 0 && frdy && ena && v[SEL];
    e_fwd_ena = (q.size() > 0 && frdy) || e_byp;
    e_fwd_v   = e_byp ? v : (q.size() > 0 ? q[0] : '0);
    @(negedge CLK);
  endtask

  // Clock edge: update the model with what was accepted / popped.
  task automatic advance();
    @(posedge CLK);
    if (!nRST) q.delete();
    else begin
      if (e_fwd_ena && !e_byp) void'(q.pop_front());
      if (in_enq.ena && in_enq.v[SEL] && !e_byp) q.push_back(in_enq.v);
    end
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (forward_enq.ena !== 1'b0) begin
      failures++;
      $display("FAIL rst_fwd_ena got=%b exp=0", forward_enq.ena);
    end
    checks++;
    if (in_enq.rdy !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_rdy got=%b exp=1", in_enq.rdy);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (in_enq.rdy !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_rdy_follow got=%b exp=0", in_enq.rdy);
    end
    advance();
    nRST = 1'b1;
  endtask

  task automatic test_direct();
    word_t w;
    w = 128'h1;
    drive(1'b1, w, 1'b1, 1'b1);
    checks++;
    if (out_enq.ena !== 1'b1 || out_enq.v !== w) begin
      failures++;
      $display("FAIL direct_out got=%b/%h exp=1/%h", out_enq.ena, out_enq.v, w);
    end
    checks++;
    if (forward_enq.ena !== 1'b0) begin
      failures++;
      $display("FAIL direct_fwd_ena got=%b exp=0", forward_enq.ena);
    end
    advance();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, fw(i), 1'b1, 1'b0);
      checks++;
      if (in_enq.rdy !== 1'b1 || out_enq.ena !== 1'b0) begin
        failures++;
        $display("FAIL fill_rdy[%0d] got rdy=%b oena=%b exp=1/0",
                 i, in_enq.rdy, out_enq.ena);
      end
      advance();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (in_enq.rdy !== 1'b0) begin
      failures++;
      $display("FAIL full_in_rdy got=%b exp=0", in_enq.rdy);
    end
    advance();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      checks++;
      if (forward_enq.ena !== 1'b1 || forward_enq.v !== fw(i)) begin
        failures++;
        $display("FAIL drain[%0d] got=%b/%h exp=1/%h",
                 i, forward_enq.ena, forward_enq.v, fw(i));
      end
      advance();
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (forward_enq.ena !== 1'b0) begin
      failures++;
      $display("FAIL drained_empty got=%b exp=0", forward_enq.ena);
    end
    advance();
  endtask

  task automatic test_simul();
    word_t exp_order[4];
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, fw(i), 1'b1, 1'b0);
      advance();
    end
    drive(1'b1, fw(5), 1'b1, 1'b1);
    checks++;
    if (forward_enq.ena !== 1'b1 || forward_enq.v !== fw(1)) begin
      failures++;
      $display("FAIL simul_head got=%b/%h exp=1/%h",
               forward_enq.ena, forward_enq.v, fw(1));
    end
    advance();
    drive(1'b1, fw(6), 1'b1, 1'b0);
    checks++;
    if (in_enq.rdy !== 1'b1) begin
      failures++;
      $display("FAIL simul_cnt3 got=%b exp=1", in_enq.rdy);
    end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (in_enq.rdy !== 1'b0) begin
      failures++;
      $display("FAIL simul_cnt4 got=%b exp=0", in_enq.rdy);
    end
    advance();
    exp_order = '{fw(2), fw(3), fw(5), fw(6)};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      checks++;
      if (forward_enq.ena !== 1'b1 || forward_enq.v !== exp_order[i]) begin
        failures++;
        $display("FAIL simul_order[%0d] got=%b/%h exp=1/%h",
                 i, forward_enq.ena, forward_enq.v, exp_order[i]);
      end
      advance();
    end
  endtask

  task automatic test_out_stall();
    drive(1'b0, fw(7), 1'b0, 1'b1);
    checks++;
    if (in_enq.rdy !== 1'b0 || out_enq.ena !== 1'b0) begin
      failures++;
      $display("FAIL stall got rdy=%b oena=%b exp=0/0",
               in_enq.rdy, out_enq.ena);
    end
    advance();
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (forward_enq.ena !== 1'b0) begin
      failures++;
      $display("FAIL stall_nothing got=%b exp=0", forward_enq.ena);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, fw(8), 1'b1, 1'b0);
    advance();
    drive(1'b1, fw(9), 1'b1, 1'b0);
    advance();
    in_enq.ena      = 1'b0;
    forward_enq.rdy = 1'b1;
    #1;
    checks++;
    if (forward_enq.ena !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_ena got=%b exp=1", forward_enq.ena);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (forward_enq.ena !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_ena got=%b exp=0", forward_enq.ena);
    end
    @(posedge CLK);
    q.delete();
    #1;
    nRST = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (forward_enq.ena !== 1'b0 || in_enq.rdy !== 1'b1) begin
      failures++;
      $display("FAIL post_reset got fena=%b rdy=%b exp=0/1",
               forward_enq.ena, in_enq.rdy);
    end
    advance();
  endtask

  task automatic test_bypass();
    word_t w;
    w = fw(8'hAA);
    drive(1'b1, w, 1'b1, 1'b1);
    checks++;
    if (forward_enq.ena !== BYP || (BYP && forward_enq.v !== w)) begin
      failures++;
      $display("FAIL bypass_same got=%b/%h exp=%b/%h",
               forward_enq.ena, forward_enq.v, BYP, w);
    end
    advance();
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (forward_enq.ena !== !BYP || (!BYP && forward_enq.v !== w)) begin
      failures++;
      $display("FAIL bypass_next got=%b/%h exp=%b/%h",
               forward_enq.ena, forward_enq.v, !BYP, w);
    end
    advance();
  endtask

  task automatic test_random();
    logic  ena, ordy, frdy;
    word_t w;
    for (int n = 0; n < 400; n++) begin
      ordy = ($urandom_range(0, 3) != 0);
      frdy = ($urandom_range(0, 2) == 0);
      w    = rnd_word();
      ena  = ordy && (q.size() < DEPTH) && $urandom_range(0, 1);
      drive(ena, w, ordy, frdy);
      checks++;
      if (in_enq.rdy !== e_in_rdy || out_enq.ena !== e_out_ena ||
          forward_enq.ena !== e_fwd_ena ||
          (e_out_ena && out_enq.v !== w) ||
          (e_fwd_ena && forward_enq.v !== e_fwd_v)) begin
        failures++;
        $display("FAIL rand[%0d] got rdy=%b oe=%b fe=%b fv=%h exp %b/%b/%b/%h",
                 n, in_enq.rdy, out_enq.ena, forward_enq.ena,
                 forward_enq.v, e_in_rdy, e_out_ena, e_fwd_ena, e_fwd_v);
      end
      advance();
    end
  endtask

  initial begin
    in_enq.ena      = 1'b0;
    in_enq.v        = '0;
    out_enq.rdy     = 1'b1;
    forward_enq.rdy = 1'b0;
    #1;
    test_reset();
    test_direct();
    test_full();
    test_simul();
    test_out_stall();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
